// File: rtl/fifo_pkt_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkt_wr_ctrl_if
//  Purpose  : Source-stream, FIFO-write and status bundle of fifo_pkt_wr_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface fifo_pkt_wr_ctrl_if #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic             in_err;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             snap_wraddr;
  logic             roll_wraddr;
  logic             fifo_full;
  logic [ADDR:0]    room_avail;
  logic             busy;
  logic [15:0]      pkt_ok_cnt;
  logic [15:0]      pkt_drop_cnt;

  // master is the surrounding source/FIFO side, slave is the controller
  modport master (
    output in_valid, in_sop, in_eop, in_err, in_data, fifo_full, room_avail,
    input  in_ready, write_en, write_data, snap_wraddr, roll_wraddr,
           busy, pkt_ok_cnt, pkt_drop_cnt
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_err, in_data, fifo_full, room_avail,
    output in_ready, write_en, write_data, snap_wraddr, roll_wraddr,
           busy, pkt_ok_cnt, pkt_drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pkt_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkt_wr_ctrl
//  Purpose  : Packet write controller; commits good packets with a snap pulse
//             and rolls back bad or overflowing ones.
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_pkt_wr_ctrl #(
  parameter int ADDR      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 16
) (
  input  wire logic         wrclk,
  input  wire logic         rst_wrclk,
  fifo_pkt_wr_ctrl_if.slave bus
);

  localparam int                 c_len_w    = $clog2(MAX_BEATS + 1);
  localparam logic [c_len_w-1:0] c_max_len  = c_len_w'(MAX_BEATS);
  localparam logic [c_len_w-1:0] c_len_one  = c_len_w'(1);
  localparam logic [ADDR:0]      c_cred_one = (ADDR+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PKT    = 2'd1,
    S_COMMIT = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR:0]      r_credit;
  logic [ADDR:0]      w_credit_nxt;
  logic [c_len_w-1:0] r_len;
  logic [c_len_w-1:0] w_len_nxt;
  logic               r_drop_last;
  logic               w_drop_last_nxt;
  logic               r_write_en;
  logic [WIDTH-1:0]   r_write_data;
  logic               r_snap;
  logic               r_roll;
  logic [15:0]        r_ok_cnt;
  logic [15:0]        r_drop_cnt;

  logic w_ready;
  logic w_accept;
  logic w_overflow;
  logic w_write;
  logic w_snap;
  logic w_roll;
  logic w_ok_inc;
  logic w_drop_inc;

  assign w_ready    = (r_state != S_COMMIT);
  assign w_accept   = bus.in_valid & w_ready;
  assign w_overflow = (r_credit == '0) || (r_len == c_max_len) || bus.fifo_full;

  always_comb begin
    w_state_nxt     = r_state;
    w_credit_nxt    = r_credit;
    w_len_nxt       = r_len;
    w_drop_last_nxt = 1'b0;
    w_write         = 1'b0;
    w_snap          = 1'b0;
    w_roll          = 1'b0;
    w_ok_inc        = 1'b0;
    w_drop_inc      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept && bus.in_sop) begin
          w_credit_nxt = bus.room_avail;
          w_len_nxt    = '0;
          if (bus.room_avail == '0) begin
            // nothing written yet, so no rollback is needed
            w_drop_inc      = 1'b1;
            w_state_nxt     = S_DROP;
            w_drop_last_nxt = bus.in_eop;
          end else if (bus.in_eop && bus.in_err) begin
            w_roll     = 1'b1;
            w_drop_inc = 1'b1;
          end else begin
            w_write      = 1'b1;
            w_credit_nxt = bus.room_avail - c_cred_one;
            w_len_nxt    = c_len_one;
            w_state_nxt  = bus.in_eop ? S_COMMIT : S_PKT;
          end
        end
      end

      S_PKT: begin
        if (w_accept) begin
          if (bus.in_sop) begin
            w_roll      = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = S_DROP;
          end else if (bus.in_eop && (bus.in_err || w_overflow)) begin
            w_roll      = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_overflow) begin
            w_roll      = 1'b1;
            w_drop_inc  = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            w_write      = 1'b1;
            w_credit_nxt = r_credit - c_cred_one;
            w_len_nxt    = r_len + c_len_one;
            w_state_nxt  = bus.in_eop ? S_COMMIT : S_PKT;
          end
        end
      end

      S_COMMIT: begin
        w_snap      = 1'b1;
        w_ok_inc    = 1'b1;
        w_state_nxt = S_IDLE;
      end

      S_DROP: begin
        // r_drop_last: the dropped packet's eop already arrived with its sop
        if (r_drop_last || (w_accept && bus.in_eop)) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wrclk) begin
    if (rst_wrclk) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_len        <= '0;
      r_drop_last  <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_data <= '0;
      r_snap       <= 1'b0;
      r_roll       <= 1'b0;
      r_ok_cnt     <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_credit    <= w_credit_nxt;
      r_len       <= w_len_nxt;
      r_drop_last <= w_drop_last_nxt;
      r_write_en  <= w_write;
      r_snap      <= w_snap;
      r_roll      <= w_roll;
      if (w_write) begin
        r_write_data <= bus.in_data;
      end
      if (w_ok_inc) begin
        r_ok_cnt <= r_ok_cnt + 16'd1;
      end
      if (w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.write_en     = r_write_en;
  assign bus.write_data   = r_write_data;
  assign bus.snap_wraddr  = r_snap;
  assign bus.roll_wraddr  = r_roll;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.pkt_ok_cnt   = r_ok_cnt;
  assign bus.pkt_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_pkt_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_pkt_wr_ctrl
//  Purpose  : Directed and random checks of fifo_pkt_wr_ctrl against a
//             packet-level reference model and a snap/rollback FIFO model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pkt_wr_ctrl;

  localparam int ADDR      = 4;
  localparam int WIDTH     = 32;
  localparam int MAX_BEATS = 4;
  localparam int DEPTH     = 1 << ADDR;
  localparam int AW1       = ADDR + 1;

  logic wrclk = 1'b0;
  logic rst_wrclk = 1'b1;
  always #5 wrclk = ~wrclk;

  fifo_pkt_wr_ctrl_if #(.ADDR(ADDR), .WIDTH(WIDTH)) bus ();

  fifo_pkt_wr_ctrl #(.ADDR(ADDR), .WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .wrclk     (wrclk),
    .rst_wrclk (rst_wrclk),
    .bus       (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // FIFO model: write pointer, committed (snap) pointer, read pointer
  logic [WIDTH-1:0] mem [DEPTH];
  int  wptr = 0;
  int  sptr = 0;
  int  rptr = 0;
  bit  drain_en = 1'b0;

  assign bus.room_avail = AW1'(DEPTH - (wptr - rptr));
  assign bus.fifo_full  = ((wptr - rptr) >= DEPTH);

  // reference model: packet in progress, discarding, commit pending
  logic [WIDTH-1:0] cur_pkt [$];
  logic [WIDTH-1:0] sb_q [$];
  bit               m_open, m_discard, m_linger, m_commit;
  int               m_credit;
  bit               x_we, x_snap, x_roll;
  logic [WIDTH-1:0] x_wd;
  logic [15:0]      x_ok, x_drop;
  int               seen_we, seen_snap, seen_roll;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_discard = 0; m_linger = 0; m_commit = 0; m_credit = 0;
    x_we = 0; x_snap = 0; x_roll = 0; x_wd = '0; x_ok = '0; x_drop = '0;
    cur_pkt.delete();
    sb_q.delete();
    wptr = 0; sptr = 0; rptr = 0;
  endtask

  task automatic put(input logic [WIDTH-1:0] d);
    x_we = 1; x_wd = d; m_credit--;
    cur_pkt.push_back(d);
  endtask

  task automatic abort(input bit to_discard);
    x_roll = 1; x_drop++;
    m_open = 0; m_discard = to_discard;
    cur_pkt.delete();
  endtask

  task automatic finish_good();
    m_open = 0; m_commit = 1;
    foreach (cur_pkt[i]) sb_q.push_back(cur_pkt[i]);
    cur_pkt.delete();
  endtask

  // predicts the registered outputs visible after the coming clock edge
  task automatic model_step(input bit v, input bit s, input bit e, input bit er,
                            input logic [WIDTH-1:0] d);
    bit acc;
    bit over;
    int room;
    room = DEPTH - (wptr - rptr);
    acc  = v && !m_commit;
    x_we = 0; x_snap = 0; x_roll = 0;
    if (m_commit) begin
      m_commit = 0; x_snap = 1; x_ok++;
    end else if (m_linger) begin
      m_linger = 0; m_discard = 0;
    end else if (m_discard) begin
      if (acc && e) m_discard = 0;
    end else if (m_open) begin
      if (acc) begin
        over = (m_credit == 0) || (cur_pkt.size() >= MAX_BEATS) || (room == 0);
        if (s)                   abort(1);
        else if (e && (er || over)) abort(0);
        else if (over)           abort(1);
        else begin
          put(d);
          if (e) finish_good();
        end
      end
    end else if (acc && s) begin
      m_credit = room;
      cur_pkt.delete();
      if (room == 0) begin
        x_drop++; m_discard = 1; m_linger = e;
      end else if (e && er) begin
        x_roll = 1; x_drop++;
      end else begin
        put(d);
        if (e) finish_good();
        else   m_open = 1;
      end
    end
  endtask

  task automatic fifo_update(input bit we, input logic [WIDTH-1:0] wd, input bit sn, input bit rl);
    logic [WIDTH-1:0] exp_d;
    if (we) begin
      mem[wptr % DEPTH] = wd;
      wptr++;
    end
    if (sn) sptr = wptr;
    if (rl) wptr = sptr;
    chk("fifo_no_overrun", 32'((wptr - rptr) <= DEPTH), 32'd1);
    if (drain_en && (rptr < sptr) && ($urandom_range(1, 0) == 1)) begin
      exp_d = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_0BAD;
      chk("read_data", mem[rptr % DEPTH], exp_d);
      rptr++;
    end
  endtask

  task automatic cycle(input bit r, input bit v, input bit s, input bit e, input bit er,
                       input logic [WIDTH-1:0] d);
    bit we, sn, rl;
    logic [WIDTH-1:0] wd;
    rst_wrclk = r;
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e; bus.in_err = er; bus.in_data = d;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(!m_commit));
    chk("busy", 32'(bus.busy), 32'(m_open | m_discard | m_commit));
    chk("write_en", 32'(bus.write_en), 32'(x_we));
    if (x_we) chk("write_data", bus.write_data, x_wd);
    chk("snap_wraddr", 32'(bus.snap_wraddr), 32'(x_snap));
    chk("roll_wraddr", 32'(bus.roll_wraddr), 32'(x_roll));
    chk("pkt_ok_cnt", 32'(bus.pkt_ok_cnt), 32'(x_ok));
    chk("pkt_drop_cnt", 32'(bus.pkt_drop_cnt), 32'(x_drop));
    we = bus.write_en; wd = bus.write_data; sn = bus.snap_wraddr; rl = bus.roll_wraddr;
    if (we) seen_we++;
    if (sn) seen_snap++;
    if (rl) seen_roll++;
    if (r) model_reset();
    else   model_step(v, s, e, er, d);
    @(posedge wrclk);
    #1;
    if (!r) fifo_update(we, wd, sn, rl);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic send(input int n, input logic [WIDTH-1:0] base, input bit err);
    while (m_commit) cycle(0, 0, 0, 0, 0, '0);
    for (int i = 0; i < n; i++)
      cycle(0, 1, (i == 0), (i == n - 1), err && (i == n - 1), base + WIDTH'(i));
  endtask

  task automatic start_scenario();
    cycle(1, 0, 0, 0, 0, '0);
    seen_we = 0; seen_snap = 0; seen_roll = 0;
  endtask

  task automatic expect_counts(input string tag, input int we, input int sn, input int rl,
                               input int ok, input int drop);
    chk({tag, "_writes"}, seen_we, we);
    chk({tag, "_snaps"},  seen_snap, sn);
    chk({tag, "_rolls"},  seen_roll, rl);
    chk({tag, "_ok"},     32'(bus.pkt_ok_cnt), ok);
    chk({tag, "_drop"},   32'(bus.pkt_drop_cnt), drop);
    chk({tag, "_idle"},   32'(bus.busy), 32'd0);
  endtask

  initial begin
    bit gen_open;
    bit r, v, s, e, er;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_err = 0; bus.in_data = '0;
    rst_wrclk = 1;
    repeat (2) @(posedge wrclk);
    #1;
    model_reset();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_write_en", 32'(bus.write_en), 32'd0);
    chk("rst_write_data", bus.write_data, 32'd0);
    chk("rst_snap", 32'(bus.snap_wraddr), 32'd0);
    chk("rst_roll", 32'(bus.roll_wraddr), 32'd0);
    chk("rst_ok", 32'(bus.pkt_ok_cnt), 32'd0);
    chk("rst_drop", 32'(bus.pkt_drop_cnt), 32'd0);

    start_scenario(); send(4, 32'd1, 0); idle(3);
    expect_counts("good4", 4, 1, 0, 1, 0);

    start_scenario(); send(3, 32'h20, 1); idle(3);
    expect_counts("err3", 2, 0, 1, 0, 1);

    start_scenario(); wptr = 14; sptr = 14; send(4, 32'h30, 0); idle(3);
    expect_counts("room2", 2, 0, 1, 0, 1);

    start_scenario(); send(6, 32'h40, 0); send(1, 32'h50, 0); idle(3);
    expect_counts("maxbeats", 5, 1, 1, 1, 1);

    start_scenario();
    cycle(0, 1, 1, 0, 0, 32'h61);
    cycle(0, 1, 0, 0, 0, 32'h62);
    cycle(0, 1, 1, 0, 0, 32'h63);
    cycle(0, 1, 0, 0, 0, 32'h64);
    cycle(0, 1, 0, 1, 0, 32'h65);
    send(3, 32'h70, 0); idle(3);
    expect_counts("nosop_eop", 5, 1, 1, 1, 1);

    start_scenario();
    cycle(0, 1, 1, 0, 0, 32'h81);
    cycle(1, 1, 0, 0, 0, 32'h82);
    chk("midrst_write_en", 32'(bus.write_en), 32'd0);
    chk("midrst_write_data", bus.write_data, 32'd0);
    chk("midrst_snap", 32'(bus.snap_wraddr), 32'd0);
    chk("midrst_roll", 32'(bus.roll_wraddr), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    seen_we = 0; seen_snap = 0; seen_roll = 0;
    send(2, 32'h90, 0); idle(3);
    expect_counts("midrst", 2, 1, 0, 1, 0);

    // random traffic, FIFO reader toggles to exercise low room
    start_scenario();
    drain_en = 1;
    gen_open = 0;
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(3, 0) != 0);
      s  = gen_open ? ($urandom_range(24, 0) == 0) : ($urandom_range(9, 0) != 0);
      e  = ($urandom_range(2, 0) == 0);
      er = ($urandom_range(7, 0) == 0);
      r  = ($urandom_range(599, 0) == 0);
      if (v && !m_commit) begin
        if (s)      gen_open = !e;
        else if (e) gen_open = 0;
      end
      if (r) gen_open = 0;
      if ($urandom_range(63, 0) == 0) drain_en = !drain_en;
      cycle(r, v, s, e, er, WIDTH'($urandom));
    end
    drain_en = 1;
    idle(120);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fifo_pkt_wr_ctrl.md
FIFO_PKT_WR_CTRL -- requirements
Module: fifo_pkt_wr_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: wrclk, rst_wrclk.
REQ-002 Parameters SHALL be:
- ADDR, 4, FIFO address width.
- WIDTH, 32, data width.
- MAX_BEATS, 16, maximum beats per packet; legal range 1..2^ADDR.
REQ-003 Ports SHALL be:
- wrclk  in  1  clock.
- rst_wrclk  in  1  sync active-high reset.
- in_valid  in  1  source beat valid.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet.
- in_err  in  1  packet bad; sampled on eop beat only.
- in_data  in  WIDTH  beat payload.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- write_en  out  1  FIFO write strobe.
- write_data  out  WIDTH  FIFO write data.
- snap_wraddr  out  1  commit pulse; makes all writes since the last snap visible to the reader.
- roll_wraddr  out  1  rollback pulse; restores the FIFO write pointer to the last snap.
- fifo_full  in  1  FIFO full flag.
- room_avail  in  ADDR+1  free entries; reflects every write_en by the next cycle.
- busy  out  1  state != IDLE.
- pkt_ok_cnt  out  16  committed packets, wrapping.
- pkt_drop_cnt  out  16  dropped packets, wrapping.

Function
REQ-004 The FSM SHALL have states IDLE, PKT, COMMIT and DROP, encoded in 2 bits.
REQ-005 in_ready SHALL be 1 in IDLE, PKT and DROP, and 0 in COMMIT; it is combinational from state.
REQ-006 write_en, write_data, snap_wraddr and roll_wraddr SHALL be registered outputs.
REQ-007 A beat accepted and written in cycle N SHALL produce write_en=1 and write_data=in_data in cycle N+1.
REQ-008 In IDLE, an accepted beat without in_sop SHALL be discarded with no write and no counter change.
REQ-009 In IDLE, an accepted sop beat SHALL latch credit=room_avail and set len=0.
- If credit==0, the beat is not written, pkt_drop_cnt increments, and the next state is DROP.
- If in_eop is also set, DROP returns to IDLE in the following cycle.
REQ-010 Each written beat SHALL decrement credit by 1 and increment len by 1.
- Credit is ADDR+1 bits and never underflows.
REQ-011 In PKT, a non-eop beat arriving with credit==0, len==MAX_BEATS or fifo_full=1 SHALL be treated as overflow:
- the beat is not written;
- roll_wraddr=1 in cycle N+1;
- pkt_drop_cnt increments;
- the next state is DROP.
REQ-012 A good eop beat accepted in cycle N (in_err=0, no overflow) SHALL:
- be written in cycle N+1;
- give state COMMIT in cycle N+1;
- give snap_wraddr=1 in cycle N+2 with state IDLE;
- increment pkt_ok_cnt.
REQ-013 An eop beat with in_err=1, or an eop beat meeting the overflow condition, SHALL:
- not be written;
- give roll_wraddr=1 in cycle N+1;
- increment pkt_drop_cnt;
- give next state IDLE.
REQ-014 A single-beat packet (sop & eop) SHALL follow REQ-012 or REQ-013 directly from IDLE.
REQ-015 An in_sop beat accepted in PKT (missing eop) SHALL:
- abort the open packet: roll_wraddr=1 in N+1, pkt_drop_cnt increments;
- discard the new sop beat;
- enter DROP.
REQ-016 DROP SHALL consume beats without writing until an accepted eop beat, then return to IDLE; in_sop is ignored in DROP.
REQ-017 snap_wraddr and roll_wraddr SHALL each be single-cycle pulses, SHALL never be asserted together, and SHALL never coincide with write_en.
- A sop accepted in the cycle of a snap or roll pulse produces its write one cycle later.

Reset
REQ-018 While rst_wrclk=1 at a wrclk edge, the block SHALL set:
- state=IDLE;
- write_en=0, write_data=0, snap_wraddr=0, roll_wraddr=0;
- credit=0, len=0;
- pkt_ok_cnt=0, pkt_drop_cnt=0.
- busy=0 follows from state.
REQ-019 Reset asserted mid-packet SHALL abandon the packet without issuing roll_wraddr; the FIFO pointers are reset separately.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- 4-beat good packet (data 1..4), room_avail=16 -> write_en high 4 cycles with data 1..4; snap_wraddr one cycle after the last write; pkt_ok_cnt=1.
- 3-beat packet with in_err=1 on eop -> 2 writes; roll_wraddr 1 cycle after eop; no snap; pkt_drop_cnt=1.
- room_avail=2, 4-beat packet -> 2 writes; roll on the 3rd beat; the 4th (eop) beat consumed in DROP; back in IDLE; pkt_drop_cnt=1.
- MAX_BEATS=4, 6-beat packet -> 4 writes, roll, DROP until eop; then an immediate 1-beat good packet -> write, then snap; ok=1, drop=1.
- sop, 2 beats, then a new sop without eop -> roll; DROP until the next eop; the following packet commits normally.
- Reset asserted during beat 2 of a packet -> all outputs 0 on the next cycle; a subsequent good packet commits with pkt_ok_cnt=1.
